// File: rtl/edge_count_meter_pkg.sv
// Shared constants and helpers for pin-measuring blocks.
package edge_count_meter_pkg;

  localparam int GATE_WIDTH_DEFAULT  = 22;
  localparam int COUNT_WIDTH_DEFAULT = 8;

  // Largest value representable in 'width' bits (all ones).
  function automatic logic [31:0] sat_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/edge_count_meter_input_sync_edge.sv
// Three-flop synchroniser for an asynchronous pin plus a one-cycle rising-edge pulse.
// A pin transition shows up on EDGE after two CLK edges.
module input_sync_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic I,
  output logic EDGE
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= I;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s1 is the metastability stage; only s2/s3 feed logic.
  assign EDGE = s2 & ~s3;

endmodule

// File: rtl/edge_count_meter.sv
// Counts rising edges of an asynchronous pin over 2^GATE_WIDTH-clock windows and
// publishes the saturated count with a one-cycle VALID; the first window after reset is discarded.
module edge_count_meter
  import edge_count_meter_pkg::*;
#(
  parameter int GATE_WIDTH  = GATE_WIDTH_DEFAULT,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   I,
  output logic [COUNT_WIDTH-1:0] O,
  output logic                   VALID,
  output logic                   OVF
);

  localparam logic [GATE_WIDTH-1:0]  GATE_MAX = GATE_WIDTH'(sat_max(GATE_WIDTH));
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = COUNT_WIDTH'(sat_max(COUNT_WIDTH));

  logic                   edge_pulse;
  logic [GATE_WIDTH-1:0]  g;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                   sat;
  logic                   first;
  logic                   wend;
  logic                   cnt_full;
  logic [COUNT_WIDTH-1:0] tot;

  input_sync_edge u_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .I     (I),
    .EDGE  (edge_pulse)
  );

  assign wend     = (g == GATE_MAX);
  assign cnt_full = (cnt == CNT_MAX);
  // An edge on the closing cycle still belongs to the closing window.
  assign tot      = cnt_full ? CNT_MAX : cnt + COUNT_WIDTH'(edge_pulse);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      g     <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
      first <= 1'b1;
      O     <= '0;
      VALID <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      g     <= g + GATE_WIDTH'(1);
      VALID <= 1'b0;
      if (wend) begin
        // The window that started at reset release is partial, so it is dropped.
        if (first) begin
          first <= 1'b0;
        end else begin
          O     <= tot;
          OVF   <= sat | (cnt_full & edge_pulse);
          VALID <= 1'b1;
        end
        cnt <= '0;
        sat <= 1'b0;
      end else if (edge_pulse) begin
        if (cnt_full) begin
          sat <= 1'b1;
        end else begin
          cnt <= cnt + COUNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
